// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline slice.
// Holds the register-number width, the hard-wired zero register and the
// encodings of the ALU operand forwarding selects.
package mips_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

endpackage

// File: rtl/fwd_sel.sv
// Forwarding select for one ALU source operand.
// Ports:
//   src          source register of the EX instruction
//   mem_dest     destination held in EX/MEM
//   mem_regwrite EX/MEM instruction writes the register file
//   wb_dest      destination held in MEM/WB
//   wb_regwrite  MEM/WB instruction writes the register file
//   fwd          FWD_MEM, FWD_WB or FWD_NONE
module fwd_sel
  import mips_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_regwrite,
  input  logic [REG_W-1:0] wb_dest,
  input  logic             wb_regwrite,
  output logic [1:0]       fwd
);

  // The MEM stage holds the newer result, so it is tested first. Register $0
  // is hard-wired to zero and is never forwarded.
  always_comb begin
    fwd = FWD_NONE;
    if (mem_regwrite && (mem_dest != REG_ZERO) && (mem_dest == src))
      fwd = FWD_MEM;
    else if (wb_regwrite && (wb_dest != REG_ZERO) && (wb_dest == src))
      fwd = FWD_WB;
  end

endmodule

// File: rtl/dest_reg_pipe.sv
// Carries the EX-stage write-register number and its flags through the
// EX/MEM and MEM/WB pipeline registers, derives the ALU forwarding selects
// and the load-use stall request, and counts the stalls taken.
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   ex_dest, ex_regwrite,
//   ex_memread                destination and flags of the EX instruction
//   ex_rs, ex_rt              sources of the EX instruction
//   id_rs, id_rt              sources of the ID instruction
//   hold                      freeze all state
//   flush_ex                  send a bubble into EX/MEM instead of EX
//   mem_dest, mem_regwrite,
//   mem_memread               EX/MEM register contents
//   wb_dest, wb_regwrite      MEM/WB register contents
//   fwd_a, fwd_b              forwarding selects for ALU operands A and B
//   load_use_stall            stall request for the front of the pipe
//   stall_cnt                 saturating count of stall cycles taken
module dest_reg_pipe
  import mips_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             hold,
  input  logic             flush_ex,
  output logic [REG_W-1:0] mem_dest,
  output logic             mem_regwrite,
  output logic             mem_memread,
  output logic [REG_W-1:0] wb_dest,
  output logic             wb_regwrite,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             load_use_stall,
  output logic [CNT_W-1:0] stall_cnt
);

  // Pipeline registers. hold freezes everything and outranks flush_ex, so a
  // bubble requested during a freeze is simply not inserted on that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_dest     <= REG_ZERO;
      mem_regwrite <= 1'b0;
      mem_memread  <= 1'b0;
      wb_dest      <= REG_ZERO;
      wb_regwrite  <= 1'b0;
    end else if (!hold) begin
      wb_dest     <= mem_dest;
      wb_regwrite <= mem_regwrite;
      if (flush_ex) begin
        mem_dest     <= REG_ZERO;
        mem_regwrite <= 1'b0;
        mem_memread  <= 1'b0;
      end else begin
        mem_dest     <= ex_dest;
        mem_regwrite <= ex_regwrite;
        mem_memread  <= ex_memread;
      end
    end
  end

  // A load in EX whose target is read by the instruction in ID cannot be
  // forwarded in time. The raw EX flag is used because the hazard must be
  // seen while the load is still in EX.
  assign load_use_stall = ex_memread && (ex_dest != REG_ZERO) &&
                          ((ex_dest == id_rs) || (ex_dest == id_rt));

  // Stall counter: counts edges on which a stall is actually taken and sticks
  // at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (!hold && load_use_stall && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

  fwd_sel u_fwd_a (
    .src          (ex_rs),
    .mem_dest     (mem_dest),
    .mem_regwrite (mem_regwrite),
    .wb_dest      (wb_dest),
    .wb_regwrite  (wb_regwrite),
    .fwd          (fwd_a)
  );

  fwd_sel u_fwd_b (
    .src          (ex_rt),
    .mem_dest     (mem_dest),
    .mem_regwrite (mem_regwrite),
    .wb_dest      (wb_dest),
    .wb_regwrite  (wb_regwrite),
    .fwd          (fwd_b)
  );

endmodule

// File: tb/tb_dest_reg_pipe.sv
// Self-checking bench for dest_reg_pipe: directed scenarios followed by a
// randomized run, all compared against a stage-array reference model.
module tb_dest_reg_pipe;

  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic [4:0]       ex_dest;
  logic             ex_regwrite;
  logic             ex_memread;
  logic [4:0]       ex_rs;
  logic [4:0]       ex_rt;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             hold;
  logic             flush_ex;
  logic [4:0]       mem_dest;
  logic             mem_regwrite;
  logic             mem_memread;
  logic [4:0]       wb_dest;
  logic             wb_regwrite;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             load_use_stall;
  logic [CNT_W-1:0] stall_cnt;

  int checks;
  int errors;

  // Reference model: stage 0 is EX/MEM, stage 1 is MEM/WB.
  int mDest[2];
  bit mRw[2];
  bit mMr;
  int mCnt;

  dest_reg_pipe #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_dest        (ex_dest),
    .ex_regwrite    (ex_regwrite),
    .ex_memread     (ex_memread),
    .ex_rs          (ex_rs),
    .ex_rt          (ex_rt),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .hold           (hold),
    .flush_ex       (flush_ex),
    .mem_dest       (mem_dest),
    .mem_regwrite   (mem_regwrite),
    .mem_memread    (mem_memread),
    .wb_dest        (wb_dest),
    .wb_regwrite    (wb_regwrite),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b),
    .load_use_stall (load_use_stall),
    .stall_cnt      (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a hung run.
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish, required finish before time limit");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] expFwd(input int src);
    if (src == 0) return 2'b00;
    for (int s = 0; s < 2; s++)
      if (mRw[s] && mDest[s] == src) return (s == 0) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  function automatic bit expStall();
    return ex_memread && ex_dest != 0 && (ex_dest == id_rs || ex_dest == id_rt);
  endfunction

  task automatic resetModel();
    mDest[0] = 0; mDest[1] = 0;
    mRw[0] = 0; mRw[1] = 0;
    mMr = 0;
    mCnt = 0;
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".mem_dest"}, 32'(mem_dest), 32'(mDest[0]));
    checkOutput({tag, ".mem_regwrite"}, 32'(mem_regwrite), 32'(mRw[0]));
    checkOutput({tag, ".mem_memread"}, 32'(mem_memread), 32'(mMr));
    checkOutput({tag, ".wb_dest"}, 32'(wb_dest), 32'(mDest[1]));
    checkOutput({tag, ".wb_regwrite"}, 32'(wb_regwrite), 32'(mRw[1]));
    checkOutput({tag, ".fwd_a"}, 32'(fwd_a), 32'(expFwd(int'(ex_rs))));
    checkOutput({tag, ".fwd_b"}, 32'(fwd_b), 32'(expFwd(int'(ex_rt))));
    checkOutput({tag, ".load_use_stall"}, 32'(load_use_stall), 32'(expStall()));
    checkOutput({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(mCnt));
  endtask

  // Drive one set of inputs mid-cycle and check the combinational outputs.
  task automatic applyStimulus(input logic [4:0] d, input logic rw, input logic mr,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] irs, input logic [4:0] irt,
                               input logic h, input logic f, input string tag);
    ex_dest = d; ex_regwrite = rw; ex_memread = mr;
    ex_rs = rs; ex_rt = rt; id_rs = irs; id_rt = irt;
    hold = h; flush_ex = f;
    #1;
    checkAll({tag, ".comb"});
  endtask

  // Advance the model by one edge, clock the DUT, and compare.
  task automatic stepClock(input string tag);
    if (!hold) begin
      if (expStall()) mCnt = (mCnt < CNT_MAX) ? mCnt + 1 : CNT_MAX;
      mDest[1] = mDest[0];
      mRw[1] = mRw[0];
      mDest[0] = flush_ex ? 0 : int'(ex_dest);
      mRw[0] = flush_ex ? 1'b0 : ex_regwrite;
      mMr = flush_ex ? 1'b0 : ex_memread;
    end
    @(posedge clk);
    #1;
    checkAll({tag, ".edge"});
  endtask

  task automatic idle(input string tag);
    applyStimulus(5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetModel();
    rst_n = 1'b0;
    ex_dest = '0; ex_regwrite = 0; ex_memread = 0;
    ex_rs = '0; ex_rt = '0; id_rs = '0; id_rt = '0;
    hold = 0; flush_ex = 0;
    #1;
    checkAll("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Latency of the destination through both stages.
    applyStimulus(5'd9, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, "lat");
    stepClock("lat1");
    checkOutput("lat.mem_dest_9", 32'(mem_dest), 32'd9);
    idle("lat");
    stepClock("lat2");
    checkOutput("lat.wb_dest_9", 32'(wb_dest), 32'd9);

    // Back-to-back writers of $8: MEM beats WB.
    applyStimulus(5'd8, 1'b1, 1'b0, 5'd8, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, "b2b");
    stepClock("b2b1");
    stepClock("b2b2");
    checkOutput("b2b.fwd_a_mem", 32'(fwd_a), 32'h2);
    applyStimulus(5'd0, 1'b1, 1'b0, 5'd0, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0, "zero");
    stepClock("zero1");
    stepClock("zero2");
    checkOutput("zero.fwd_a_none", 32'(fwd_a), 32'h0);

    // Load-use on $5, then the same with a $0 load.
    applyStimulus(5'd5, 1'b1, 1'b1, 5'd0, 5'd0, 5'd1, 5'd5, 1'b0, 1'b0, "lu");
    checkOutput("lu.stall_high", 32'(load_use_stall), 32'd1);
    stepClock("lu");
    checkOutput("lu.cnt_one", 32'(stall_cnt), 32'd1);
    applyStimulus(5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, "lu0");
    checkOutput("lu0.stall_low", 32'(load_use_stall), 32'd0);
    stepClock("lu0");

    // Freeze for three cycles with changing EX inputs and a live stall.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(5'(i + 3), 1'b1, 1'b1, 5'd0, 5'd0, 5'(i + 3), 5'd0, 1'b1, 1'b0, "hold");
      stepClock("hold");
    end
    applyStimulus(5'd6, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, "holdflush");
    stepClock("holdflush");

    // Flush while WB takes the previous EX/MEM contents.
    applyStimulus(5'd12, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, "fl");
    stepClock("fl_pre");
    applyStimulus(5'd7, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, "fl");
    stepClock("fl");
    checkOutput("fl.mem_dest_zero", 32'(mem_dest), 32'd0);
    checkOutput("fl.wb_dest_prev", 32'(wb_dest), 32'd12);

    // Asynchronous reset in the middle of a cycle with the pipe loaded.
    applyStimulus(5'd3, 1'b1, 1'b1, 5'd0, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0, "mid");
    stepClock("mid_load");
    idle("mid_idle");
    rst_n = 1'b0;
    resetModel();
    #1;
    checkAll("midreset");
    stepClock("midreset_held");
    @(negedge clk);
    rst_n = 1'b1;

    // Saturation of the stall counter.
    applyStimulus(5'd4, 1'b1, 1'b1, 5'd0, 5'd0, 5'd4, 5'd4, 1'b0, 1'b0, "sat");
    for (int i = 0; i < 20; i++) stepClock("sat");
    checkOutput("sat.cnt_max", 32'(stall_cnt), 32'hF);

    // Randomized traffic over a small register range to provoke matches.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        rst_n = 1'b0;
        resetModel();
        #1;
        rst_n = 1'b1;
      end
      applyStimulus(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 1'($urandom_range(0, 4) == 0),
                    1'($urandom_range(0, 4) == 0), "rnd");
      stepClock("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
